divider_seq: RTL and testbench

- Parametrised sequential restoring divider; generalises the fixed 4-bit by 2-bit combinational divider array.
- Computes one quotient bit per clock, MSB first, using a single subtract/compare stage.
- Uses valid/ready handshakes on the input and output sides, plus explicit divide-by-zero handling.
- Sits between operand producers and arithmetic consumers in the example designs.

---
 rtl/divider_seq.sv | 144 ++++++++++++++
 tb/tb_divider_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with
// valid/ready handshakes on both sides and a short path for a zero divisor.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting dividend bits through the subtract/compare stage
// DONE  | result registered, waiting for the output handshake
module divider_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rmd_q, rmd_d;
  logic          dbz_q, dbz_d;
  logic          ov_q, ov_d;

  logic [VW:0]   p, diff, rem_nxt;
  logic          qbit, accept, last;
  logic          unused_rem_msb;

  // The partial remainder never exceeds the divisor, so its top bit stays zero.
  assign unused_rem_msb = rem_q[VW];

  assign in_ready    = (state_q == S_IDLE) & ~rst;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = ov_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    p       = {rem_q[VW-1:0], dvd_q[DW-1]};
    qbit    = (p >= {1'b0, dvs_q});
    diff    = p - {1'b0, dvs_q};
    rem_nxt = qbit ? diff : p;
    accept  = in_valid & in_ready;
    last    = (cnt_q == CW'(1));

    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    ov_d    = ov_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = CW'(DW);
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rmd_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        dvd_d = {dvd_q[DW-2:0], qbit};
        rem_d = rem_nxt;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_DONE;
          quo_d   = {dvd_q[DW-2:0], qbit};
          rmd_d   = rem_nxt[VW-1:0];
          dbz_d   = 1'b0;
          ov_d    = 1'b1;
        end
      end
      S_DONE: begin
        // A zero-divisor result enters DONE straight from IDLE and is
        // presented one cycle later.
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq (DW=8, VW=4): directed latency/handshake cases plus a
// randomized sweep scored against plain A/B and A%B from a queue of accepted operands.
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       busy;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] b;
  } op_t;

  op_t exp_q[$];
  op_t mon_op;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_in = 0;
  int  n_out = 0;

  divider_seq #(.DW(8), .VW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted operand pair must come back exactly once, in order.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_in  = 0;
      n_out = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 32'(1), 32'(0));
        end else begin
          mon_op = exp_q.pop_front();
          if (mon_op.b == 4'd0) begin
            check_eq("sb_q", 32'(quotient), 32'(255));
            check_eq("sb_r", 32'(remainder), int'(mon_op.a) % 16);
            check_eq("sb_dbz", 32'(div_by_zero), 32'(1));
          end else begin
            check_eq("sb_q", 32'(quotient), int'(mon_op.a) / int'(mon_op.b));
            check_eq("sb_r", 32'(remainder), int'(mon_op.a) % int'(mon_op.b));
            check_eq("sb_dbz", 32'(div_by_zero), 32'(0));
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{a: dividend, b: divisor});
        n_in++;
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("ready_wait", 32'(in_ready), 32'(1));
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic accept_op(input logic [7:0] a, input logic [3:0] b);
    wait_ready();
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int lat,
                        input logic [7:0] eq, input logic [3:0] er, input logic ed);
    int k;
    out_ready = 1'b1;
    accept_op(a, b);
    check_eq("busy_after_accept", 32'(busy), 32'(1));
    check_eq("ready_low_busy", 32'(in_ready), 32'(0));
    wait_valid(k);
    check_eq("latency", k, lat);
    check_eq("dir_q", 32'(quotient), 32'(eq));
    check_eq("dir_r", 32'(remainder), 32'(er));
    check_eq("dir_dbz", 32'(div_by_zero), 32'(ed));
    @(posedge clk); #1;
    check_eq("valid_drop", 32'(out_valid), 32'(0));
    check_eq("ready_back", 32'(in_ready), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  seen;
    logic accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_q", 32'(quotient), 32'(0));
    check_eq("rst_r", 32'(remainder), 32'(0));
    check_eq("rst_dbz", 32'(div_by_zero), 32'(0));
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(in_ready), 32'(1));

    run_op(8'd200, 4'd7,  8, 8'd28,  4'd4, 1'b0);
    run_op(8'd255, 4'd15, 8, 8'd17,  4'd0, 1'b0);
    run_op(8'd3,   4'd9,  8, 8'd0,   4'd3, 1'b0);
    run_op(8'd100, 4'd0,  1, 8'd255, 4'd4, 1'b1);
    run_op(8'd9,   4'd2,  8, 8'd4,   4'd1, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    accept_op(8'd200, 4'd7);
    wait_valid(k);
    check_eq("bp_latency", k, 8);
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("bp_valid_hold", 32'(out_valid), 32'(1));
      check_eq("bp_q_hold", 32'(quotient), 32'(28));
      check_eq("bp_r_hold", 32'(remainder), 32'(4));
      check_eq("bp_ready_low", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_valid_drop", 32'(out_valid), 32'(0));
    check_eq("bp_ready_back", 32'(in_ready), 32'(1));
    check_eq("bp_q_after", 32'(quotient), 32'(28));

    // Reset in the middle of RUN discards the operation.
    accept_op(8'd200, 4'd7);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_eq("rst_gates_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("abort_ready", 32'(in_ready), 32'(1));
    check_eq("abort_busy", 32'(busy), 32'(0));
    check_eq("abort_q", 32'(quotient), 32'(0));
    check_eq("abort_r", 32'(remainder), 32'(0));
    check_eq("abort_valid", 32'(out_valid), 32'(0));
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_pulse", seen, 0);
    run_op(8'd50, 4'd6, 8, 8'd8, 4'd2, 1'b0);

    // Randomized sweep with input gaps and output stalls.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(0, 15));
      k = 0;
      accepted = 1'b0;
      while (!accepted && k < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        accepted  = in_ready;
        @(posedge clk); #1;
        k++;
      end
      in_valid = 1'b0;
      if (!accepted) check_eq("sweep_accept_timeout", 32'(accepted), 32'(1));
    end
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("in_out_count", n_out, n_in);
    check_eq("final_ready", 32'(in_ready), 32'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
